// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bus: ID/EX hazard inputs and MEM handshake towards the controller,
// stage enables, flushes, memory start and performance counters back to the pipeline.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic [4:0]       id_src1;
    logic [4:0]       id_src2;
    logic             id_two_src;
    logic [4:0]       ex_dest;
    logic             ex_mem_read;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             mem_start;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side drives hazard inputs and observes the controls.
    modport master (
        output id_src1, id_src2, id_two_src, ex_dest, ex_mem_read,
               branch_taken, mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, mem_start, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_src1, id_src2, id_two_src, ex_dest, ex_mem_read,
               branch_taken, mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, mem_start, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, branch flush, memory-wait freeze.
// Controls are combinational (zero latency); a memory wait freezes every stage until ready.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    state_t              w_state_eff;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_cnt_nxt;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic                w_freeze;
    logic                w_load_use;
    logic                w_src1_hit;
    logic                w_src2_hit;
    logic                w_stall_inc;
    logic                w_flush_inc;

    // Controls during reset are decoded as if the FSM were already back in IDLE.
    assign w_state_eff = rst ? IDLE : r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = '0;
        case (r_state)
            IDLE: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    w_state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    w_state_nxt = IDLE;
                end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                    w_state_nxt = MEM_ERR;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                end
            end
            MEM_ERR: begin
                w_state_nxt = MEM_ERR;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_freeze = 1'b0;
        case (w_state_eff)
            IDLE:     w_freeze = bus.mem_req && !bus.mem_ready;
            MEM_WAIT: w_freeze = !bus.mem_ready;
            MEM_ERR:  w_freeze = 1'b1;
            default:  w_freeze = 1'b0;
        endcase
    end

    // Register 0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign w_src1_hit = (bus.id_src1 == bus.ex_dest);
    assign w_src2_hit = bus.id_two_src && (bus.id_src2 == bus.ex_dest);
    assign w_load_use = bus.ex_mem_read && (bus.ex_dest != 5'd0) && (w_src1_hit || w_src2_hit);

    always_comb begin
        bus.pc_en      = 1'b1;
        bus.ifid_en    = 1'b1;
        bus.idex_en    = 1'b1;
        bus.exmem_en   = 1'b1;
        bus.memwb_en   = 1'b1;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        if (w_freeze) begin
            bus.pc_en    = 1'b0;
            bus.ifid_en  = 1'b0;
            bus.idex_en  = 1'b0;
            bus.exmem_en = 1'b0;
            bus.memwb_en = 1'b0;
        end else if (bus.branch_taken) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
        end else if (w_load_use) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_flush = 1'b1;
        end
    end

    // One start pulse per access: only IDLE can launch, MEM_WAIT never re-launches.
    assign bus.mem_start = (w_state_eff == IDLE) && bus.mem_req;
    assign bus.mem_err   = (w_state_eff == MEM_ERR);

    assign w_stall_inc = w_freeze || (w_load_use && !bus.branch_taken);
    assign w_flush_inc = bus.branch_taken && !w_freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed table, multi-cycle corner sequences and
// randomized traffic against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
    localparam int T   = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();
    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] t_s1, t_s2, t_dest;
    logic       t_two, t_mrd, t_br, t_req, t_rdy;

    // Model: is an access outstanding, has it timed out, how long has it waited.
    logic m_busy, m_err;
    int   m_waited, m_stall, m_flush;

    typedef struct {
        string      name;
        logic [4:0] s1, s2, dest;
        logic       two, mrd, br, req, rdy;
        logic [7:0] exp;  // {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush,mem_start}
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_in(input logic [4:0] s1, input logic [4:0] s2, input logic two,
                          input logic [4:0] dest, input logic mrd, input logic br,
                          input logic req, input logic rdy);
        t_s1 = s1; t_s2 = s2; t_two = two; t_dest = dest;
        t_mrd = mrd; t_br = br; t_req = req; t_rdy = rdy;
        bus.id_src1 = s1; bus.id_src2 = s2; bus.id_two_src = two; bus.ex_dest = dest;
        bus.ex_mem_read = mrd; bus.branch_taken = br; bus.mem_req = req; bus.mem_ready = rdy;
    endtask

    function automatic logic [8:0] dut_vec();
        return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                bus.ifid_flush, bus.idex_flush, bus.mem_start, bus.mem_err};
    endfunction

    // Returns {freeze, load_use, expected output vector}.
    function automatic logic [10:0] model_eval();
        logic frz, lu, idle;
        logic [8:0] v;
        idle = rst || (!m_busy && !m_err);
        if (rst)         frz = t_req && !t_rdy;
        else if (m_err)  frz = 1'b1;
        else if (m_busy) frz = !t_rdy;
        else             frz = t_req && !t_rdy;
        lu = t_mrd && (t_dest != 0) && ((t_s1 == t_dest) || (t_two && (t_s2 == t_dest)));
        if (frz)       v[8:2] = 7'b00000_00;
        else if (t_br) v[8:2] = 7'b11111_11;
        else if (lu)   v[8:2] = 7'b00111_01;
        else           v[8:2] = 7'b11111_00;
        v[1] = idle && t_req;
        v[0] = !rst && m_err;
        return {frz, lu, v};
    endfunction

    task automatic model_step(input logic frz, input logic lu);
        if (rst) begin
            m_busy = 0; m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0;
            return;
        end
        if (frz || (lu && !t_br)) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
        if (t_br && !frz)         m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
        if (m_err) begin
        end else if (m_busy) begin
            if (t_rdy) m_busy = 0;
            else if (m_waited == T) begin m_busy = 0; m_err = 1; end
            else m_waited++;
        end else if (t_req && !t_rdy) begin
            m_busy = 1; m_waited = 0;
        end
    endtask

    // Inputs are already applied (after a negedge); check, clock once, advance the model.
    task automatic cycle();
        logic [10:0] e;
        #1;
        e = model_eval();
        chk("outputs", {23'd0, dut_vec()}, {23'd0, e[8:0]});
        chk("stall_cnt", {28'd0, bus.stall_cnt}, m_stall);
        chk("flush_cnt", {28'd0, bus.flush_cnt}, m_flush);
        @(posedge clk);
        model_step(e[10], e[9]);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        rst = 1'b0;
    endtask

    vec_t       tbl[11];
    logic [8:0] v;

    initial begin
        m_busy = 0; m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        tbl[0]  = '{"quiet",       0, 0, 0, 0, 0, 0, 0, 0, 8'b11111_000};
        tbl[1]  = '{"lu_src1",     5, 0, 5, 0, 1, 0, 0, 0, 8'b00111_010};
        tbl[2]  = '{"lu_src2",     1, 7, 7, 1, 1, 0, 0, 0, 8'b00111_010};
        tbl[3]  = '{"src2_unused", 1, 7, 7, 0, 1, 0, 0, 0, 8'b11111_000};
        tbl[4]  = '{"zero_reg",    0, 0, 0, 1, 1, 0, 0, 0, 8'b11111_000};
        tbl[5]  = '{"not_load",    3, 3, 3, 1, 0, 0, 0, 0, 8'b11111_000};
        tbl[6]  = '{"branch",      1, 2, 9, 1, 0, 1, 0, 0, 8'b11111_110};
        tbl[7]  = '{"branch_lu",   9, 2, 9, 1, 1, 1, 0, 0, 8'b11111_110};
        tbl[8]  = '{"mem_hit",     1, 2, 3, 1, 0, 0, 1, 1, 8'b11111_001};
        tbl[9]  = '{"mem_hit_lu",  3, 2, 3, 1, 1, 0, 1, 1, 8'b00111_011};
        tbl[10] = '{"mem_hit_br",  3, 2, 3, 1, 1, 1, 1, 1, 8'b11111_111};

        @(negedge clk);
        do_reset();
        #1;
        chk("reset_outputs", {23'd0, dut_vec()}, {23'd0, 9'b11111_0000});
        chk("reset_stall", {28'd0, bus.stall_cnt}, 0);
        chk("reset_flush", {28'd0, bus.flush_cnt}, 0);

        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].s1, tbl[i].s2, tbl[i].two, tbl[i].dest,
                   tbl[i].mrd, tbl[i].br, tbl[i].req, tbl[i].rdy);
            #1;
            v = dut_vec();
            chk(tbl[i].name, {24'd0, v[8:1]}, {24'd0, tbl[i].exp});
            cycle();
        end

        // Load-use stalls exactly one cycle.
        do_reset();
        set_in(5, 0, 0, 5, 1, 0, 0, 0);
        #1;
        chk("lu_stall_ctl", {29'd0, bus.pc_en, bus.ifid_en, bus.idex_flush}, 3'b001);
        cycle();
        chk("lu_stall_cnt", {28'd0, bus.stall_cnt}, 1);
        set_in(5, 0, 0, 6, 0, 0, 0, 0);
        #1;
        chk("lu_release", {30'd0, bus.pc_en, bus.ifid_en}, 2'b11);
        cycle();

        // Zero register never stalls.
        do_reset();
        set_in(0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        chk("zero_enables", {27'd0, bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en}, 5'b11111);
        cycle();
        chk("zero_stall_cnt", {28'd0, bus.stall_cnt}, 0);

        // Branch wins over load-use.
        do_reset();
        set_in(5, 0, 0, 5, 1, 1, 0, 0);
        #1;
        chk("br_lu_ctl", {29'd0, bus.pc_en, bus.ifid_flush, bus.idex_flush}, 3'b111);
        cycle();
        chk("br_lu_flush_cnt", {28'd0, bus.flush_cnt}, 1);
        chk("br_lu_stall_cnt", {28'd0, bus.stall_cnt}, 0);

        // Memory access ready after three low cycles.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        chk("mw_start0", {30'd0, bus.mem_start, bus.pc_en}, 2'b10);
        cycle();
        #1;
        chk("mw_start1", {30'd0, bus.mem_start, bus.pc_en}, 2'b00);
        cycle();
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        chk("mw_ready", {30'd0, bus.mem_start, bus.pc_en}, 2'b01);
        cycle();
        chk("mw_stall_cnt", {28'd0, bus.stall_cnt}, 3);
        #1;
        chk("mw_back_idle", {31'd0, bus.mem_start}, 1);
        cycle();

        // Timeout into MEM_ERR, frozen until reset.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (T + 1) cycle();
        chk("to_not_yet", {31'd0, bus.mem_err}, 0);
        cycle();
        chk("to_err", {31'd0, bus.mem_err}, 1);
        repeat (10) cycle();
        set_in(0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        chk("to_frozen", {30'd0, bus.pc_en, bus.memwb_en}, 2'b00);
        chk("to_stall_sat", {28'd0, bus.stall_cnt}, SAT);
        cycle();
        do_reset();
        #1;
        chk("to_reset_err", {31'd0, bus.mem_err}, 0);
        chk("to_reset_cnt", {24'd0, bus.stall_cnt, bus.flush_cnt}, 0);
        chk("to_reset_pc", {31'd0, bus.pc_en}, 1);

        // Stall counter saturation.
        do_reset();
        set_in(4, 0, 0, 4, 1, 0, 0, 0);
        repeat (20) cycle();
        chk("sat_stall", {28'd0, bus.stall_cnt}, SAT);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 39) == 0) || (m_err && ($urandom_range(0, 3) == 0));
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 1) == 1);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
